// File: rtl/sc_stream_counter.sv
// sc_stream_counter
//   Stochastic-to-binary converter that sits behind the SC evaluation stage.
//   After a start request it runs the upstream generator for WARMUP cycles
//   and discards stream_in during that time, because the upstream delay
//   registers are still filling. It then counts the ones in stream_in over
//   exactly 2^LEN_LOG2 cycles. The count is presented on result with
//   result_valid, and it stays there until the consumer acknowledges it.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst_n        : synchronous reset, active-high (despite the name)
//   start        : request an evaluation (sampled in IDLE and HOLD only)
//   stream_in    : stochastic bitstream from the evaluation stage
//   result_ack   : consumer accepts result (meaningful in HOLD only)
//   sng_en       : enables the upstream LFSR/SNG/delay chain (WARMUP, COUNT)
//   busy         : evaluation in progress (WARMUP, COUNT)
//   result       : ones count of the last window, CNT_W bits
//   result_valid : high exactly while a result is being held
module sc_stream_counter #(
  parameter int LEN_LOG2 = 8,
  parameter int WARMUP   = 2,
  parameter int CNT_W    = LEN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stream_in,
  input  logic             result_ack,
  output logic             sng_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid
);

  // The cycle counter is shared by WARMUP and COUNT, so it is sized for the
  // longer of the two phases.
  localparam int CYC_W = (LEN_LOG2 > $clog2(WARMUP + 1)) ? LEN_LOG2 : $clog2(WARMUP + 1);

  localparam logic [CYC_W-1:0] WARM_LAST = CYC_W'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [CYC_W-1:0] CNT_LAST  = CYC_W'((1 << LEN_LOG2) - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // With no warm-up the first sample is taken on the edge after start.
  localparam logic [1:0] ST_FIRST = (WARMUP == 0) ? ST_COUNT : ST_WARM;

  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cyc_q,   cyc_d;
  logic [CNT_W-1:0] ones_q,  ones_d;
  logic [CNT_W-1:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    ones_d   = ones_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FIRST;
          cyc_d   = '0;
          ones_d  = '0;
        end
      end
      ST_WARM: begin
        // stream_in is deliberately not looked at here.
        if (cyc_q == WARM_LAST) begin
          state_d = ST_COUNT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_COUNT: begin
        // stream_in is only used in this state. An unknown level outside
        // the counting window therefore cannot reach the count.
        ones_d = ones_q + CNT_W'(stream_in);
        cyc_d  = cyc_q + CYC_W'(1);
        if (cyc_q == CNT_LAST) begin
          result_d = ones_q + CNT_W'(stream_in);
          state_d  = ST_HOLD;
          cyc_d    = '0;
        end
      end
      ST_HOLD: begin
        if (result_ack) begin
          if (start) begin
            // Back-to-back run. result keeps the old value until the new
            // window completes.
            state_d = ST_FIRST;
            cyc_d   = '0;
            ones_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  // All outputs are decoded from registers only.
  assign sng_en       = (state_q == ST_WARM) || (state_q == ST_COUNT);
  assign busy         = sng_en;
  assign result_valid = (state_q == ST_HOLD);
  assign result       = result_q;

endmodule
